// File: rtl/jump_sequencer.sv
// jump_sequencer: multicycle control sequencer for J/JAL/JR jumps; defining JUMP_SEQUENCER_JALR_EN adds JALR decode.
module jump_sequencer #(
  parameter logic [15:0] COUNT_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic        wb_sel_pc,
  output logic [15:0] jump_count
);
  typedef enum logic [2:0] {IDLE, CAPTURE, LINK, PCWR, DONE, ERR} state_t;
  state_t state, state_nxt;
  logic [5:0] op_q, fn_q;
  logic is_j, is_jal, is_jr, is_jalr;
  assign is_j   = op_q == 6'h02;
  assign is_jal = op_q == 6'h03;
  assign is_jr  = op_q == 6'h00 && fn_q == 6'h08;
`ifdef JUMP_SEQUENCER_JALR_EN
  assign is_jalr = op_q == 6'h00 && fn_q == 6'h09;
`else
  assign is_jalr = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= '0;
      fn_q       <= '0;
      jump_count <= COUNT_RESET;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start && !flush) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (state == PCWR && jump_count != 16'hFFFF) jump_count <= jump_count + 16'd1;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? CAPTURE : IDLE;
      CAPTURE: state_nxt = (is_jal || is_jalr) ? LINK : (is_j || is_jr) ? PCWR : ERR;
      LINK:    state_nxt = PCWR;
      PCWR:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end
  // Outputs are Moore-decoded; flush only suppresses the completion/illegal pulses.
  always_comb begin
    busy      = state != IDLE;
    done      = state == DONE && !flush;
    illegal   = state == ERR && !flush;
    pc_write  = state == PCWR;
    pc_source = state == PCWR ? ((is_jr || is_jalr) ? 2'b11 : 2'b10) : 2'b00;
    reg_write = state == LINK;
    wb_sel_pc = state == LINK;
    reg_dst   = state == LINK ? (is_jalr ? 2'b01 : 2'b10) : 2'b00;
  end
endmodule

// File: tb/tb_jump_sequencer.sv
// tb_jump_sequencer: directed self-checking bench for jump_sequencer.
module tb_jump_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0, s_start = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic busy, done, illegal, pc_write, reg_write, wb_sel_pc;
  logic [1:0] pc_source, reg_dst;
  logic [15:0] jump_count;
  logic s_busy, s_done, s_illegal, s_pc_write, s_reg_write, s_wb_sel_pc;
  logic [1:0] s_pc_source, s_reg_dst;
  logic [15:0] s_count;
  logic [9:0] ctl;
  int errors = 0, checks = 0;
  // ctl = {busy, done, illegal, pc_write, pc_source, reg_write, reg_dst, wb_sel_pc}
  localparam logic [9:0] IDL   = 10'b0000000000;
  localparam logic [9:0] CAP   = 10'b1000000000;
  localparam logic [9:0] LJAL  = 10'b1000001101;
  localparam logic [9:0] LJALR = 10'b1000001011;
  localparam logic [9:0] PCJ   = 10'b1001100000;
  localparam logic [9:0] PCR   = 10'b1001110000;
  localparam logic [9:0] DN    = 10'b1100000000;
  localparam logic [9:0] ER    = 10'b1010000000;
  assign ctl = {busy, done, illegal, pc_write, pc_source, reg_write, reg_dst, wb_sel_pc};
  always #5 clk = ~clk;
  jump_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .opcode(opcode), .funct(funct),
    .busy(busy), .done(done), .illegal(illegal), .pc_write(pc_write), .pc_source(pc_source),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel_pc(wb_sel_pc), .jump_count(jump_count)
  );
  jump_sequencer #(.COUNT_RESET(16'hFFFE)) sat (
    .clk(clk), .reset(reset), .start(s_start), .flush(1'b0), .opcode(6'h02), .funct(6'h00),
    .busy(s_busy), .done(s_done), .illegal(s_illegal), .pc_write(s_pc_write), .pc_source(s_pc_source),
    .reg_write(s_reg_write), .reg_dst(s_reg_dst), .wb_sel_pc(s_wb_sel_pc), .jump_count(s_count)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #3;
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL reset_ctl ctl=%b exp=%b", ctl, IDL); end
    checks++; if (jump_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%h exp=0000", jump_count); end
    #8 reset = 1'b1;
    tick();
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL post_reset_ctl ctl=%b exp=%b", ctl, IDL); end
  endtask
  task automatic test_j();
    logic [9:0] exp [4];
    exp = '{CAP, PCJ, DN, IDL};
    opcode = 6'h02; funct = 6'h00; start = 1'b1;
    tick();
    start = 1'b0; opcode = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ctl !== exp[i]) begin errors++; $display("FAIL j cycle%0d ctl=%b exp=%b", i + 1, ctl, exp[i]); end
      if (i < 3) tick();
    end
    checks++; if (jump_count !== 16'd1) begin errors++; $display("FAIL j_count got=%h exp=0001", jump_count); end
  endtask
  task automatic test_jr();
    logic [9:0] exp [4];
    exp = '{CAP, PCR, DN, IDL};
    opcode = 6'h00; funct = 6'h08; start = 1'b1;
    tick();
    start = 1'b0; funct = 6'h09; opcode = 6'h03;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ctl !== exp[i]) begin errors++; $display("FAIL jr cycle%0d ctl=%b exp=%b", i + 1, ctl, exp[i]); end
      if (i < 3) tick();
    end
    checks++; if (jump_count !== 16'd2) begin errors++; $display("FAIL jr_count got=%h exp=0002", jump_count); end
  endtask
  task automatic test_illegal();
    logic [9:0] exp [3];
    exp = '{CAP, ER, IDL};
    opcode = 6'h04; funct = 6'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ctl !== exp[i]) begin errors++; $display("FAIL illegal cycle%0d ctl=%b exp=%b", i + 1, ctl, exp[i]); end
      if (i < 2) tick();
    end
    checks++; if (jump_count !== 16'd2) begin errors++; $display("FAIL illegal_count got=%h exp=0002", jump_count); end
  endtask
  task automatic test_jal();
    logic [9:0] exp [5];
    exp = '{CAP, LJAL, PCJ, DN, IDL};
    opcode = 6'h03; funct = 6'h00; start = 1'b1;
    tick();
    opcode = 6'h04;
    for (int i = 0; i < 5; i++) begin
      checks++; if (ctl !== exp[i]) begin errors++; $display("FAIL jal cycle%0d ctl=%b exp=%b", i + 1, ctl, exp[i]); end
      if (i == 3) start = 1'b0;
      if (i < 4) tick();
    end
    checks++; if (jump_count !== 16'd3) begin errors++; $display("FAIL jal_count got=%h exp=0003", jump_count); end
  endtask
  task automatic test_flush();
    opcode = 6'h03; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (ctl !== LJAL) begin errors++; $display("FAIL flush_link ctl=%b exp=%b", ctl, LJAL); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL flush_idle ctl=%b exp=%b", ctl, IDL); end
    tick();
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL flush_stay ctl=%b exp=%b", ctl, IDL); end
    checks++; if (jump_count !== 16'd3) begin errors++; $display("FAIL flush_count got=%h exp=0003", jump_count); end
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL flush_beats_start ctl=%b exp=%b", ctl, IDL); end
    opcode = 6'h02; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    checks++; if (ctl !== PCJ) begin errors++; $display("FAIL flush_pcwr ctl=%b exp=%b", ctl, PCJ); end
    tick();
    flush = 1'b0;
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL flush_pcwr_nodone ctl=%b exp=%b", ctl, IDL); end
    checks++; if (jump_count !== 16'd4) begin errors++; $display("FAIL flush_pcwr_count got=%h exp=0004", jump_count); end
  endtask
  task automatic test_jalr();
    opcode = 6'h00; funct = 6'h09; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (ctl !== CAP) begin errors++; $display("FAIL jalr_capture ctl=%b exp=%b", ctl, CAP); end
    tick();
`ifdef JUMP_SEQUENCER_JALR_EN
    checks++; if (ctl !== LJALR) begin errors++; $display("FAIL jalr_link ctl=%b exp=%b", ctl, LJALR); end
    tick();
    checks++; if (ctl !== PCR) begin errors++; $display("FAIL jalr_pcwr ctl=%b exp=%b", ctl, PCR); end
    tick();
    checks++; if (ctl !== DN) begin errors++; $display("FAIL jalr_done ctl=%b exp=%b", ctl, DN); end
    tick();
    checks++; if (jump_count !== 16'd5) begin errors++; $display("FAIL jalr_count got=%h exp=0005", jump_count); end
`else
    checks++; if (ctl !== ER) begin errors++; $display("FAIL jalr_illegal ctl=%b exp=%b", ctl, ER); end
    tick();
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL jalr_idle ctl=%b exp=%b", ctl, IDL); end
    checks++; if (jump_count !== 16'd4) begin errors++; $display("FAIL jalr_count got=%h exp=0004", jump_count); end
`endif
  endtask
  task automatic test_reset_mid();
    opcode = 6'h03; funct = 6'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (ctl !== LJAL) begin errors++; $display("FAIL rstmid_link ctl=%b exp=%b", ctl, LJAL); end
    #2 reset = 1'b0;
    #1;
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL rstmid_ctl ctl=%b exp=%b", ctl, IDL); end
    checks++; if (jump_count !== 16'd0) begin errors++; $display("FAIL rstmid_count got=%h exp=0000", jump_count); end
    reset = 1'b1;
    tick();
    checks++; if (ctl !== IDL) begin errors++; $display("FAIL rstmid_release ctl=%b exp=%b", ctl, IDL); end
  endtask
  task automatic test_saturation();
    checks++; if (s_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffe", s_count); end
    for (int k = 0; k < 3; k++) begin
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      tick();
      tick();
      checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL sat_done%0d got=%b exp=1", k, s_done); end
      checks++; if (s_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count%0d got=%h exp=ffff", k, s_count); end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_j();
    test_jr();
    test_illegal();
    test_jal();
    test_flush();
    test_jalr();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jump_sequencer.md
JUMP_SEQUENCER -- requirements
Module: jump_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: main control requests a jump sequence (sampled only in IDLE).
REQ-004 SHALL have port flush, input, 1 bit: synchronous abort of any sequence in progress.
REQ-005 SHALL have port opcode, input, 6 bits: Instruction[31:26].
REQ-006 SHALL have port funct, input, 6 bits: Instruction[5:0].
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-009 SHALL have port illegal, output, 1 bit: one-cycle pulse when the captured instruction is not a supported jump.
REQ-010 SHALL have port pc_write, output, 1 bit: PC register load enable.
REQ-011 SHALL have port pc_source, output, 2 bits: 00 PC+4, 01 ALUOut, 10 concatenated jump target {PC[31:28], instr[25:0], 2'b00}, 11 register A (rs).
REQ-012 SHALL have port reg_write, output, 1 bit: register file write enable.
REQ-013 SHALL have port reg_dst, output, 2 bits: 00 rt, 01 rd, 10 constant 31.
REQ-014 SHALL have port wb_sel_pc, output, 1 bit: selects PC_out (already PC+4) as the register write data.
REQ-015 SHALL have port jump_count, output, 16 bits: count of completed PC writes.

Function
REQ-016 SHALL implement the states IDLE, CAPTURE, LINK, PCWR, DONE and ERR.
REQ-017 SHALL, in IDLE with start=1 and flush=0, latch opcode and funct into internal registers and move to CAPTURE.
REQ-018 SHALL classify the latched instruction in CAPTURE: J (0x02), JAL (0x03), JR (opcode 0x00, funct 0x08); with JALR_EN, also JALR (opcode 0x00, funct 0x09).
REQ-019 SHALL go from CAPTURE to LINK for JAL/JALR, to PCWR for J/JR, and to ERR for anything else.
REQ-020 SHALL drive reg_write=1 and wb_sel_pc=1 in LINK, with reg_dst=10 for JAL and 01 for JALR, then go to PCWR.
REQ-021 SHALL perform LINK strictly before PCWR, so the link value is the pre-jump PC+4.
REQ-022 SHALL drive pc_write=1 in PCWR, with pc_source=10 for J/JAL and 11 for JR/JALR, then go to DONE.
REQ-023 SHALL increment jump_count by 1 in PCWR and saturate it at 0xFFFF.
REQ-024 SHALL drive done=1 in DONE and illegal=1 in ERR, and return to IDLE on the next cycle from either state.
REQ-025 SHALL hold pc_write, reg_write, wb_sel_pc, done and illegal at 0, pc_source=00 and reg_dst=00 in every state where they are not named above.
REQ-026 SHALL give the latency from start high (cycle 0) to done as 3 cycles for J/JR and 4 cycles for JAL/JALR.
REQ-027 SHALL ignore start whenever busy=1.
REQ-028 SHALL ignore changes on opcode and funct after capture.
REQ-029 SHALL, on flush=1 in any state, go to IDLE on the next edge with no done or illegal pulse.
REQ-030 SHALL let flush win over start when both are high in IDLE.
REQ-031 SHALL still complete a flush asserted during PCWR, including the PC write and the count increment.

Reset
REQ-032 SHALL, on reset low, immediately enter IDLE and clear the latched opcode/funct and jump_count to 0.
REQ-033 SHALL drive all outputs to 0 while reset is low, including when reset is asserted mid-sequence.
REQ-034 SHALL leave reset with the first rising edge of clk after reset goes high.

Configuration
REQ-035 SHALL, with macro JUMP_SEQUENCER_JALR_EN defined, decode JALR: link to rd via LINK, then PC from rs via PCWR.
REQ-036 SHALL, without JUMP_SEQUENCER_JALR_EN, treat opcode 0x00/funct 0x09 as illegal (ERR path) and never produce reg_dst=01 from this block.

Verification
REQ-037 SHALL cover J: start=1 with opcode=0x02 at cycle 0 -> pc_write=1, pc_source=10 at cycle 2; done=1 at cycle 3; jump_count 0->1.
REQ-038 SHALL cover JAL: opcode=0x03 -> reg_write=1, reg_dst=10, wb_sel_pc=1 at cycle 2; pc_write=1, pc_source=10 at cycle 3; done at cycle 4.
REQ-039 SHALL cover JR, then illegal: opcode=0x00, funct=0x08 -> pc_source=11 at cycle 2; then opcode=0x04 -> illegal pulse at cycle 2, no pc_write, jump_count unchanged.
REQ-040 SHALL cover flush and reset mid-sequence: flush at cycle 2 of JAL -> IDLE at cycle 3, no pc_write, no done; reset low during LINK -> all outputs 0 immediately.
REQ-041 SHALL cover saturation and JALR: preload 0xFFFE, run 3 jumps -> jump_count holds 0xFFFF; funct=0x09 -> reg_dst=01 then pc_source=11 with JUMP_SEQUENCER_JALR_EN, illegal pulse without it.
